axis_sha3_block_packer: RTL and testbench

AXI-Stream sink that sits directly downstream of the stream transmitter and feeds the SHA3 sponge core. It accepts DATA_WIDTH-bit beats and packs them byte by byte into a RATE_BITS-wide rate block. On TLAST it applies SHA3 pad10*1 padding with domain byte 0x06. It then presents each completed block to the sponge through a valid/ready handshake.

---
 rtl/axis_sha3_block_packer_pkg.sv | 17 +
 rtl/axis_sha3_block_packer_if.sv | 15 +
 rtl/axis_sha3_block_packer_byte_count.sv | 41 ++++
 rtl/axis_sha3_block_packer.sv | 135 +++++++++++++
 tb/tb_axis_sha3_block_packer.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_sha3_block_packer_pkg.sv
// rtl/axis_sha3_block_packer_pkg.sv - shared types and constants for the SHA3 block packer
package sha3_axis_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    EMIT   = 2'd2
  } state_e;

  localparam logic [7:0] SHA3_PAD_DOMAIN = 8'h06;
  localparam logic [7:0] SHA3_PAD_FINAL  = 8'h80;

  function automatic int rate_bytes(input int rate_bits);
    return rate_bits / 8;
  endfunction

endpackage

// File: rtl/axis_sha3_block_packer_if.sv
// rtl/axis_sha3_block_packer_if.sv - AXI-Stream beat bus feeding the block packer
interface axis_sha3_block_packer_if #(
  parameter int DATA_WIDTH = 16
);
  logic                    TVALID;
  logic                    TREADY;
  logic [DATA_WIDTH-1:0]   TDATA;
  logic                    TLAST;
  logic [2:0]              TUSER;
  logic [DATA_WIDTH/8-1:0] TKEEP;
  logic [1:0]              TID;

  modport master (output TVALID, TDATA, TLAST, TUSER, TKEEP, TID, input TREADY);
  modport slave  (input TVALID, TDATA, TLAST, TUSER, TKEEP, TID, output TREADY);
endinterface

// File: rtl/axis_sha3_block_packer_byte_count.sv
// rtl/axis_sha3_block_packer_byte_count.sv - valid-byte count of a beat
// AXIS_PACKER_TKEEP_EN selects TKEEP (low contiguous ones) instead of TUSER for the last beat.
module axis_byte_count #(
  parameter int KEEP_W = 2,
  parameter int NB_W   = 2
) (
  input  logic              last_i,
  input  logic [2:0]        tuser_i,
  input  logic [KEEP_W-1:0] tkeep_i,
  output logic [NB_W-1:0]   nb_o
);

  int last_cnt;

`ifdef AXIS_PACKER_TKEEP_EN
  logic run;
  logic [2:0] unused_tuser;
  assign unused_tuser = tuser_i;

  always_comb begin
    last_cnt = 0;
    run      = 1'b1;
    for (int k = 0; k < KEEP_W; k++) begin
      if (run && tkeep_i[k]) last_cnt = last_cnt + 1;
      else run = 1'b0;
    end
  end
`else
  logic [KEEP_W-1:0] unused_tkeep;
  assign unused_tkeep = tkeep_i;

  // Counts above the beat width cannot occur legally; saturate to a full beat.
  always_comb begin
    last_cnt = KEEP_W;
    if (tuser_i != 3'd0 && int'(tuser_i) <= KEEP_W) last_cnt = int'(tuser_i);
  end
`endif

  assign nb_o = last_i ? NB_W'(last_cnt) : NB_W'(KEEP_W);

endmodule

// File: rtl/axis_sha3_block_packer.sv
// rtl/axis_sha3_block_packer.sv - packs AXIS beats into SHA3 rate blocks with pad10*1
// Optional AXIS_PACKER_TKEEP_EN: last-beat byte count taken from TKEEP.
module axis_sha3_block_packer
  import sha3_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int RATE_BITS  = 1088
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  axis_sha3_block_packer_if.slave  s_axis,
  output logic [RATE_BITS-1:0]     block_data,
  output logic                     block_valid,
  input  logic                     block_ready,
  output logic                     block_last,
  output logic [1:0]               msg_id
);

  localparam int KEEP_W     = DATA_WIDTH / 8;
  localparam int RATE_BYTES = rate_bytes(RATE_BITS);
  localparam int PTR_W      = $clog2(RATE_BYTES);
  localparam int NB_W       = $clog2(KEEP_W + 1);

  state_e                         state_q, state_d;
  logic [PTR_W-1:0]               ptr_q, ptr_d;
  logic [RATE_BYTES-1:0][7:0]     buf_q, buf_d;
  logic                           pad_pending_q, pad_pending_d;
  logic                           last_q, last_d;
  logic [1:0]                     msg_id_q, msg_id_d;
  logic                           first_q, first_d;
  logic                           tready_q, tready_d;
  logic                           bvalid_q, bvalid_d;

  logic [NB_W-1:0]                nb;
  logic [KEEP_W-1:0][7:0]         tdata_b;
  logic [PTR_W:0]                 wr_end;
  logic                           beat_hs;

  axis_byte_count #(.KEEP_W(KEEP_W), .NB_W(NB_W)) u_byte_count (
    .last_i  (s_axis.TLAST),
    .tuser_i (s_axis.TUSER),
    .tkeep_i (s_axis.TKEEP),
    .nb_o    (nb)
  );

  assign tdata_b = s_axis.TDATA;
  assign beat_hs = s_axis.TVALID && tready_q;
  assign wr_end  = {1'b0, ptr_q} + (PTR_W + 1)'(nb);

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    buf_d         = buf_q;
    pad_pending_d = pad_pending_q;
    last_d        = last_q;
    msg_id_d      = msg_id_q;
    first_d       = first_q;
    unique case (state_q)
      IDLE: state_d = ACCEPT;
      ACCEPT: begin
        if (beat_hs) begin
          for (int k = 0; k < KEEP_W; k++) begin
            if (k < int'(nb)) buf_d[ptr_q + PTR_W'(k)] = tdata_b[k];
          end
          if (first_q) msg_id_d = s_axis.TID;
          first_d = s_axis.TLAST;
          if (wr_end == (PTR_W + 1)'(RATE_BYTES)) begin
            // A message ending exactly on a block boundary needs a whole pad block next.
            state_d       = EMIT;
            ptr_d         = '0;
            last_d        = 1'b0;
            pad_pending_d = s_axis.TLAST;
          end else if (s_axis.TLAST) begin
            buf_d[wr_end[PTR_W-1:0]] = buf_d[wr_end[PTR_W-1:0]] | SHA3_PAD_DOMAIN;
            buf_d[RATE_BYTES-1]      = buf_d[RATE_BYTES-1] | SHA3_PAD_FINAL;
            state_d = EMIT;
            ptr_d   = '0;
            last_d  = 1'b1;
          end else begin
            ptr_d = wr_end[PTR_W-1:0];
          end
        end
      end
      EMIT: begin
        if (block_ready) begin
          buf_d = '0;
          ptr_d = '0;
          if (pad_pending_q) begin
            buf_d[0]            = SHA3_PAD_DOMAIN;
            buf_d[RATE_BYTES-1] = SHA3_PAD_FINAL;
            last_d              = 1'b1;
            pad_pending_d       = 1'b0;
          end else begin
            state_d = ACCEPT;
            last_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    tready_d = (state_d == ACCEPT);
    bvalid_d = (state_d == EMIT);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      buf_q         <= '0;
      pad_pending_q <= 1'b0;
      last_q        <= 1'b0;
      msg_id_q      <= 2'd0;
      first_q       <= 1'b1;
      tready_q      <= 1'b0;
      bvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      buf_q         <= buf_d;
      pad_pending_q <= pad_pending_d;
      last_q        <= last_d;
      msg_id_q      <= msg_id_d;
      first_q       <= first_d;
      tready_q      <= tready_d;
      bvalid_q      <= bvalid_d;
    end
  end

  assign s_axis.TREADY = tready_q;
  assign block_data    = buf_q;
  assign block_valid   = bvalid_q;
  assign block_last    = last_q;
  assign msg_id        = msg_id_q;

endmodule

// File: tb/tb_axis_sha3_block_packer.sv
// tb/tb_axis_sha3_block_packer.sv - self-checking bench for axis_sha3_block_packer
module tb_axis_sha3_block_packer;

  localparam int DW  = 16;
  localparam int RB  = 1088;
  localparam int NBY = RB / 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_sha3_block_packer_if #(.DATA_WIDTH(DW)) axis ();

  logic [RB-1:0] block_data;
  logic          block_valid;
  logic          block_ready;
  logic          block_last;
  logic [1:0]    msg_id;

  axis_sha3_block_packer #(.DATA_WIDTH(DW), .RATE_BITS(RB)) dut (
    .ACLK        (clk),
    .ARESETn     (rst_n),
    .s_axis      (axis),
    .block_data  (block_data),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_last  (block_last),
    .msg_id      (msg_id)
  );

  typedef struct {
    logic [RB-1:0] data;
    logic          last;
    logic [1:0]    id;
  } blk_t;

  typedef struct {
    int         len;
    logic [1:0] tid;
    int         nblk;
    bit         rnd;
  } vec_t;

  blk_t exp_q[$];
  int   tot = 0;
  int   bad = 0;
  int   blk_seen;
  bit   auto_rdy;
  bit   rnd_rdy;
  bit   beat_hs;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_blk(input string nm, input logic [RB-1:0] act, input logic [RB-1:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      for (int i = 0; i < NBY; i++) begin
        if (act[i*8 +: 8] !== req[i*8 +: 8]) begin
          $display("FAIL %s byte=%0d actual=%h required=%h", nm, i, act[i*8 +: 8], req[i*8 +: 8]);
          break;
        end
      end
    end
  endtask

  task automatic tick();
    logic bv, br, tr, bl;
    logic [RB-1:0] bd;
    logic [1:0] bi;
    blk_t e;
    if (auto_rdy) block_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    bv = block_valid; br = block_ready; tr = axis.TREADY;
    bd = block_data;  bl = block_last;  bi = msg_id;
    beat_hs = axis.TVALID && tr;
    if (bv) begin
      chk("tready_low_in_emit", {63'd0, tr}, 64'd0);
      if (exp_q.size() == 0) begin
        tot++; bad++;
        $display("FAIL unexpected_block actual=valid required=none");
      end else begin
        chk_blk(br ? "block_data" : "stall_block_data", bd, exp_q[0].data);
        if (br) begin
          e = exp_q.pop_front();
          chk("block_last", {63'd0, bl}, {63'd0, e.last});
          chk("msg_id", {62'd0, bi}, {62'd0, e.id});
          blk_seen++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Reference: message ++ 0x06 ++ zeros up to the next rate multiple, final byte |= 0x80.
  task automatic push_model(input logic [7:0] msg[$], input logic [1:0] tid);
    int len = msg.size();
    int nb  = len / NBY + 1;
    for (int b = 0; b < nb; b++) begin
      blk_t e;
      e.data = '0;
      for (int i = 0; i < NBY; i++) begin
        int idx = b * NBY + i;
        logic [7:0] v;
        v = (idx < len) ? msg[idx] : ((idx == len) ? 8'h06 : 8'h00);
        if (b == nb - 1 && i == NBY - 1) v = v | 8'h80;
        e.data[i*8 +: 8] = v;
      end
      e.last = (b == nb - 1);
      e.id   = tid;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_beat(input string nm);
    int guard = 0;
    do begin
      tick();
      guard++;
    end while (!beat_hs && guard < 2000);
    if (!beat_hs) begin
      tot++; bad++;
      $display("FAIL %s actual=timeout required=handshake", nm);
    end
  endtask

  task automatic send_bytes(input logic [7:0] msg[$], input logic [1:0] tid);
    int len    = msg.size();
    int nbeats = (len + 1) / 2;
    for (int bt = 0; bt < nbeats; bt++) begin
      bit lst = (bt == nbeats - 1);
      int nbb = (lst && (len - 2 * bt) < 2) ? 1 : 2;
      logic [7:0] hi;
      if ($urandom_range(0, 3) == 0) begin
        axis.TVALID = 1'b0;
        tick();
      end
      hi = (nbb == 2) ? msg[2*bt+1] : 8'($urandom);
      axis.TVALID = 1'b1;
      axis.TLAST  = lst;
      axis.TDATA  = {hi, msg[2*bt]};
      axis.TID    = (bt == 0) ? tid : 2'($urandom);
`ifdef AXIS_PACKER_TKEEP_EN
      axis.TKEEP = (nbb == 2) ? 2'b11 : 2'b01;
      axis.TUSER = 3'($urandom);
`else
      axis.TKEEP = 2'($urandom);
      axis.TUSER = !lst ? 3'($urandom) : ((nbb == 1) ? 3'd1 : ($urandom_range(0, 1) ? 3'd0 : 3'd2));
`endif
      wait_beat("beat_timeout");
    end
    axis.TVALID = 1'b0;
    axis.TLAST  = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() > 0 && guard < 3000) begin
      tick();
      guard++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    tick();
    tick();
    chk("no_extra_block", {63'd0, block_valid}, 64'd0);
  endtask

  task automatic rand_msg(input int len, output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_tready"}, {63'd0, axis.TREADY}, 64'd0);
    chk({pfx, "_block_valid"}, {63'd0, block_valid}, 64'd0);
    chk({pfx, "_block_last"}, {63'd0, block_last}, 64'd0);
    chk({pfx, "_msg_id"}, {62'd0, msg_id}, 64'd0);
    chk_blk({pfx, "_block_data"}, block_data, '0);
  endtask

  vec_t tbl[$];
  logic [7:0] msg[$];
  blk_t e0;

  initial begin
    rst_n = 1'b0;
    axis.TVALID = 1'b0; axis.TDATA = '0; axis.TLAST = 1'b0;
    axis.TUSER = '0; axis.TKEEP = '0; axis.TID = '0;
    block_ready = 1'b0; auto_rdy = 1'b1; rnd_rdy = 1'b0;

    tbl = '{
      '{len: 1,   tid: 2'd1, nblk: 1, rnd: 1'b0},
      '{len: 2,   tid: 2'd3, nblk: 1, rnd: 1'b0},
      '{len: 3,   tid: 2'd0, nblk: 1, rnd: 1'b1},
      '{len: 50,  tid: 2'd2, nblk: 1, rnd: 1'b1},
      '{len: 135, tid: 2'd1, nblk: 1, rnd: 1'b0},
      '{len: 136, tid: 2'd2, nblk: 2, rnd: 1'b0},
      '{len: 136, tid: 2'd3, nblk: 2, rnd: 1'b1},
      '{len: 137, tid: 2'd0, nblk: 2, rnd: 1'b1},
      '{len: 271, tid: 2'd1, nblk: 2, rnd: 1'b0},
      '{len: 272, tid: 2'd2, nblk: 3, rnd: 1'b1}
    };

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    chk("tready_after_reset", {63'd0, axis.TREADY}, 64'd1);

    // Single short beat with a hand-built expected block.
    e0.data = '0;
    e0.data[7:0] = 8'hAB;
    e0.data[15:8] = 8'h06;
    e0.data[RB-1 -: 8] = 8'h80;
    e0.last = 1'b1;
    e0.id = 2'd2;
    exp_q.push_back(e0);
    blk_seen = 0;
    axis.TVALID = 1'b1; axis.TLAST = 1'b1; axis.TDATA = 16'h00AB; axis.TID = 2'd2;
`ifdef AXIS_PACKER_TKEEP_EN
    axis.TUSER = 3'd0; axis.TKEEP = 2'b01;
`else
    axis.TUSER = 3'd1; axis.TKEEP = 2'b10;
`endif
    wait_beat("single_beat_timeout");
    axis.TVALID = 1'b0; axis.TLAST = 1'b0;
    drain();
    chk("single_beat_blocks", 64'(blk_seen), 64'd1);

    foreach (tbl[v]) begin
      rnd_rdy = tbl[v].rnd;
      blk_seen = 0;
      rand_msg(tbl[v].len, msg);
      push_model(msg, tbl[v].tid);
      send_bytes(msg, tbl[v].tid);
      drain();
      chk($sformatf("blocks_len%0d", tbl[v].len), 64'(blk_seen), 64'(tbl[v].nblk));
    end
    rnd_rdy = 1'b0;

    // Sponge stalls for 10 cycles while a block is presented.
    auto_rdy = 1'b0;
    block_ready = 1'b0;
    msg = '{8'h5A};
    push_model(msg, 2'd1);
    send_bytes(msg, 2'd1);
    for (int g = 0; g < 20 && !block_valid; g++) tick();
    repeat (10) tick();
    chk("stall_valid_held", {63'd0, block_valid}, 64'd1);
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
    chk("tready_after_accept", {63'd0, axis.TREADY}, 64'd1);
    chk("valid_drop_after_accept", {63'd0, block_valid}, 64'd0);
    chk("stall_block_consumed", 64'(exp_q.size()), 64'd0);
    auto_rdy = 1'b1;

    // Reset in the middle of a message discards the partial block.
    for (int b = 0; b < 20; b++) begin
      axis.TVALID = 1'b1; axis.TLAST = 1'b0;
      axis.TDATA = 16'($urandom); axis.TID = 2'd3; axis.TKEEP = 2'b11;
      wait_beat("mid_beat_timeout");
    end
    axis.TVALID = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    chk("tready_after_midreset", {63'd0, axis.TREADY}, 64'd1);
    blk_seen = 0;
    msg = '{8'hC3};
    push_model(msg, 2'd2);
    send_bytes(msg, 2'd2);
    drain();
    chk("post_reset_blocks", 64'(blk_seen), 64'd1);

    rnd_rdy = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int len = $urandom_range(1, 300);
      logic [1:0] tid = 2'($urandom);
      blk_seen = 0;
      rand_msg(len, msg);
      push_model(msg, tid);
      send_bytes(msg, tid);
      drain();
      chk($sformatf("rand_blocks_len%0d", len), 64'(blk_seen), 64'(len / NBY + 1));
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
